ask_bit_sync: RTL



---
 rtl/ask_bit_sync.sv | 113 +++++++++++
 1 files changed

// File: rtl/ask_bit_sync.sv
// ASK bit synchronizer: hysteresis slicer, early/late phase tracker and bit sampler
// with an edge-window lock detector.
module ask_bit_sync #(
  parameter int SPS        = 8,
  parameter int HYST       = 0,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [13:0] din,
  input  logic signed [13:0] gate,
  output logic               dout,
  output logic               dout_valid,
  output logic               locked
);

  localparam int CW   = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int GW   = $clog2(LOCK_CNT + 1);
  localparam int BW   = $clog2(UNLOCK_CNT + 1);

  localparam logic [CW-1:0]        CNT_LAST = CW'(SPS - 1);
  localparam logic [CW-1:0]        CNT_HALF = CW'(SPS / 2);
  localparam logic [CW-1:0]        CNT_WRAP = CW'(SPS - 2);
  localparam logic [GW-1:0]        GOOD_MAX = GW'(LOCK_CNT);
  localparam logic [BW-1:0]        BAD_MAX  = BW'(UNLOCK_CNT);
  localparam logic signed [14:0]   HYST_X   = 15'(HYST);

  logic signed [14:0] din_x, gate_x, hi, lo;
  logic               hard_q, hard_d, hard_dly_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dout_q, dout_d, valid_q, valid_d, locked_q, locked_d;
  logic [GW-1:0]      good_q, good_d;
  logic [BW-1:0]      bad_q, bad_d;
  logic               sym_edge, early, late, in_win;

  assign din_x  = {din[13], din};
  assign gate_x = {gate[13], gate};
  assign hi     = gate_x + HYST_X;
  assign lo     = gate_x - HYST_X;

  assign sym_edge = hard_q ^ hard_dly_q;
  assign early    = sym_edge && (cnt_q != '0) && (cnt_q < CNT_HALF);
  assign late     = sym_edge && (cnt_q >= CNT_HALF);
  assign in_win   = (cnt_q == CNT_LAST) || (cnt_q == CW'(0)) || (cnt_q == CW'(1));

  always_comb begin
    hard_d   = hard_q;
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    dout_d   = dout_q;
    valid_d  = 1'b0;
    good_d   = good_q;
    bad_d    = bad_q;
    locked_d = locked_q;

    if (din_x > hi) begin
      hard_d = 1'b1;
    end else if (din_x < lo) begin
      hard_d = 1'b0;
    end

    // Early edge: hold the counter one cycle; late edge: skip one count.
    if (early) begin
      cnt_d = cnt_q;
    end else if (late) begin
      cnt_d = (cnt_q >= CNT_WRAP) ? cnt_q - CNT_WRAP : cnt_q + CW'(2);
    end

    if (cnt_q == CNT_HALF) begin
      dout_d  = hard_q;
      valid_d = 1'b1;
    end

    if (sym_edge) begin
      if (in_win) begin
        bad_d = '0;
        if (good_q != GOOD_MAX) good_d = good_q + GW'(1);
        if (good_d == GOOD_MAX) locked_d = 1'b1;
      end else begin
        good_d = '0;
        if (bad_q != BAD_MAX) bad_d = bad_q + BW'(1);
        if (bad_d == BAD_MAX) locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hard_q     <= 1'b0;
      hard_dly_q <= 1'b0;
      cnt_q      <= '0;
      dout_q     <= 1'b0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      good_q     <= '0;
      bad_q      <= '0;
    end else begin
      hard_q     <= hard_d;
      hard_dly_q <= hard_q;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign locked     = locked_q;

endmodule
